parity_filter_rng: RTL and testbench

Parametrised successor to the parity-filter byte generator. It XOR-folds groups of `PARITY_LEN` raw entropy bits into single filtered bits and assembles `WORD_WIDTH` filtered bits into one word. One debounced button press yields exactly one word, which is delivered over a valid/ready handshake. It sits between the raw entropy source (already synchronised to `high_Freq_Clk`) and the downstream consumer. An optional repetition-count health test can abort a word in progress.

---
 rtl/parity_filter_rng.sv | 176 +++++++++++++++++
 tb/tb_parity_filter_rng.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/parity_filter_rng.sv
// Parity-filter random word generator: XOR-folds raw entropy bits into a word per debounced press.
// Optional repetition-count health test enabled by defining PARITY_RNG_HEALTH_EN.
module parity_filter_rng #(
    parameter int WORD_WIDTH      = 8,
    parameter int PARITY_LEN      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REP_LIMIT       = 32
) (
    input  logic                  high_Freq_Clk,
    input  logic                  reset,
    input  logic                  raw_Bit,
    input  logic                  button_Trig,
    input  logic                  word_Ready,
    output logic [WORD_WIDTH-1:0] random_Word,
    output logic                  word_Valid,
    output logic                  busy,
    output logic                  health_Fail
);

    localparam int RCW = $clog2(PARITY_LEN) + 1;
    localparam int BCW = $clog2(WORD_WIDTH) + 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [RCW-1:0] RAW_LAST = RCW'(PARITY_LEN - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WORD_WIDTH - 1);
    localparam logic [DBW-1:0] DB_MAX   = DBW'(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] DB_PRE   = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [DBW-1:0]          db_q, db_d;
    logic                    press;
    logic                    acc_q, acc_d;
    logic [RCW-1:0]          raw_cnt_q, raw_cnt_d;
    logic [BCW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]   sh_q, sh_d;
    logic [WORD_WIDTH-1:0]   word_q, word_d;
    logic                    valid_q, valid_d;
    logic                    filt;

`ifdef PARITY_RNG_HEALTH_EN
    localparam int HCW = $clog2(REP_LIMIT) + 1;
    localparam logic [HCW-1:0] REP_MAX = HCW'(REP_LIMIT);

    logic [HCW-1:0] rep_q, rep_d, rep_nxt;
    logic           last_q, last_d;
    logic           fail_q, fail_d;

    assign health_Fail = fail_q;
`else
    assign health_Fail = 1'b0;
`endif

    // Debounce: count consecutive low samples, saturate, pulse once on reaching the limit.
    always_comb begin
        db_d = db_q;
        if (sync2_q)
            db_d = '0;
        else if (db_q != DB_MAX)
            db_d = db_q + 1'b1;
    end

    assign press = !sync2_q && (db_q == DB_PRE);
    assign filt  = acc_q ^ raw_Bit;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        raw_cnt_d = raw_cnt_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        word_d    = word_q;
        valid_d   = valid_q;
`ifdef PARITY_RNG_HEALTH_EN
        rep_d     = rep_q;
        last_d    = last_q;
        fail_d    = fail_q;
        rep_nxt   = (rep_q == '0 || raw_Bit != last_q) ? HCW'(1) : rep_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (press && !health_Fail) begin
                    state_d   = S_COLLECT;
                    acc_d     = 1'b0;
                    raw_cnt_d = '0;
                    bit_cnt_d = '0;
                    sh_d      = '0;
`ifdef PARITY_RNG_HEALTH_EN
                    rep_d     = '0;
`endif
                end
            end
            S_COLLECT: begin
                if (raw_cnt_q == RAW_LAST) begin
                    sh_d      = {sh_q[WORD_WIDTH-2:0], filt};
                    acc_d     = 1'b0;
                    raw_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        word_d  = {sh_q[WORD_WIDTH-2:0], filt};
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else begin
                    acc_d     = filt;
                    raw_cnt_d = raw_cnt_q + 1'b1;
                end
`ifdef PARITY_RNG_HEALTH_EN
                rep_d  = rep_nxt;
                last_d = raw_Bit;
                // A tripped health test wins over a word completing on the same edge.
                if (rep_nxt == REP_MAX) begin
                    fail_d  = 1'b1;
                    state_d = S_IDLE;
                    word_d  = word_q;
                    valid_d = valid_q;
                end
`endif
            end
            S_HOLD: begin
                if (valid_q && word_Ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge high_Freq_Clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_q      <= '0;
            acc_q     <= 1'b0;
            raw_cnt_q <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
`ifdef PARITY_RNG_HEALTH_EN
            rep_q     <= '0;
            last_q    <= 1'b0;
            fail_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sync1_q   <= button_Trig;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            acc_q     <= acc_d;
            raw_cnt_q <= raw_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
`ifdef PARITY_RNG_HEALTH_EN
            rep_q     <= rep_d;
            last_q    <= last_d;
            fail_q    <= fail_d;
`endif
        end
    end

    assign random_Word = word_q;
    assign word_Valid  = valid_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_parity_filter_rng.sv
// Randomized self-checking bench for parity_filter_rng against a group-XOR word model.
module tb_parity_filter_rng;

    localparam int W  = 8;
    localparam int P  = 4;
    localparam int D  = 16;
    localparam int R  = 32;
    localparam int NB = W * P;

    logic         high_Freq_Clk = 1'b0;
    logic         reset;
    logic         raw_Bit;
    logic         button_Trig;
    logic         word_Ready;
    logic [W-1:0] random_Word;
    logic         word_Valid;
    logic         busy;
    logic         health_Fail;

    int n_chk = 0;
    int n_err = 0;

    parity_filter_rng #(
        .WORD_WIDTH(W), .PARITY_LEN(P), .DEBOUNCE_CYCLES(D), .REP_LIMIT(R)
    ) dut (
        .high_Freq_Clk(high_Freq_Clk),
        .reset        (reset),
        .raw_Bit      (raw_Bit),
        .button_Trig  (button_Trig),
        .word_Ready   (word_Ready),
        .random_Word  (random_Word),
        .word_Valid   (word_Valid),
        .busy         (busy),
        .health_Fail  (health_Fail)
    );

    always #5 high_Freq_Clk = ~high_Freq_Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge high_Freq_Clk);
        #1;
    endtask

    // Each group of P raw bits XORs to one filtered bit; the first filtered bit lands in the MSB.
    function automatic logic [W-1:0] ref_word(input logic [NB-1:0] pat);
        int unsigned r = 0;
        for (int g = 0; g < W; g++) begin
            int ones = 0;
            for (int j = 0; j < P; j++) ones += int'(pat[g*P+j]);
            r = (r * 2) + (ones % 2);
        end
        return W'(r);
    endfunction

    task automatic press_to_collect(input string tag);
        button_Trig = 1'b0;
        repeat (D + 1) tick();
        chk({tag, "_busy_early"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_busy_entry"}, 32'(busy), 32'd1);
        button_Trig = 1'b1;
    endtask

    task automatic collect(input string tag, input logic [NB-1:0] pat);
        for (int i = 0; i < NB; i++) begin
            raw_Bit = pat[i];
            tick();
            if (i == NB - 2) chk({tag, "_valid_early"}, 32'(word_Valid), 32'd0);
        end
    endtask

    task automatic run_word(input string tag, input logic [NB-1:0] pat, input int hold,
                            input bit press_in_hold);
        logic [W-1:0] exp;
        exp        = ref_word(pat);
        word_Ready = (hold == 0);
        press_to_collect(tag);
        collect(tag, pat);
        chk({tag, "_valid"}, 32'(word_Valid), 32'd1);
        chk({tag, "_word"}, 32'(random_Word), 32'(exp));
        if (hold > 0) begin
            if (press_in_hold) button_Trig = 1'b0;
            repeat (hold) tick();
            button_Trig = 1'b1;
            repeat (3) tick();
            chk({tag, "_hold_valid"}, 32'(word_Valid), 32'd1);
            chk({tag, "_hold_word"}, 32'(random_Word), 32'(exp));
            chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
            word_Ready = 1'b1;
        end
        tick();
        chk({tag, "_xfer_valid"}, 32'(word_Valid), 32'd0);
        chk({tag, "_xfer_busy"}, 32'(busy), 32'd0);
        word_Ready = 1'b0;
        repeat (4) tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_kept_word"}, 32'(random_Word), 32'(exp));
    endtask

    initial begin
        logic [NB-1:0] pat;
        bit seen;

        reset       = 1'b1;
        raw_Bit     = 1'b0;
        button_Trig = 1'b1;
        word_Ready  = 1'b0;
        repeat (3) tick();
        chk("rst_word", 32'(random_Word), 32'd0);
        chk("rst_valid", 32'(word_Valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_health", 32'(health_Fail), 32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // Short press must be rejected.
        button_Trig = 1'b0;
        repeat (10) tick();
        button_Trig = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen |= busy;
        end
        chk("deb_reject", 32'(seen), 32'd0);

        // Groups 1000,0000 -> alternating filtered bits.
        for (int i = 0; i < NB; i++) pat[i] = (i % 8 == 0);
        run_word("aa", pat, 0, 1'b0);
        chk("aa_const", 32'(random_Word), 32'hAA);

        // Groups 1110 with backpressure and an ignored press during HOLD.
        for (int i = 0; i < NB; i++) pat[i] = (i % 4 != 3);
        run_word("ff", pat, 20, 1'b1);
        chk("ff_const", 32'(random_Word), 32'hFF);

        for (int n = 0; n < 5; n++) begin
            pat = NB'($urandom);
            if (pat == '0 || pat == '1) pat[0] = ~pat[0];
            run_word($sformatf("rnd%0d", n), pat, int'($urandom_range(0, 5)), 1'b0);
        end
        chk("health_clear", 32'(health_Fail), 32'd0);

        // Reset mid-COLLECT aborts with no partial word.
        press_to_collect("rst");
        for (int i = 0; i < 10; i++) begin
            raw_Bit = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        #2;
        chk("rst_mid_word", 32'(random_Word), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_valid", 32'(word_Valid), 32'd0);
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            seen |= word_Valid | busy;
        end
        chk("rst_no_activity", 32'(seen), 32'd0);

        pat = '1;
`ifdef PARITY_RNG_HEALTH_EN
        press_to_collect("hlth");
        collect("hlth", pat);
        chk("hlth_fail", 32'(health_Fail), 32'd1);
        chk("hlth_valid", 32'(word_Valid), 32'd0);
        chk("hlth_busy", 32'(busy), 32'd0);
        button_Trig = 1'b0;
        repeat (D + 4) tick();
        button_Trig = 1'b1;
        chk("hlth_blocked", 32'(busy), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("hlth_rst", 32'(health_Fail), 32'd0);
`else
        run_word("const1", pat, 0, 1'b0);
        chk("const1_word", 32'(random_Word), 32'd0);
        chk("const1_health", 32'(health_Fail), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
